// File: rtl/conv1_relu_pool.sv
// conv1 channel-map consumer: snapshots one map, applies ReLU, 2x2/stride-2 max-pool and
// shift requantisation with u8 saturation, then streams pooled pixels over valid/ready.
module conv1_relu_pool #(
   parameter int OUT1_H = 14,
   parameter int OUT1_W = 13,
   parameter int CHAN   = 10,
   parameter int SHIFT  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic signed [23:0] fmap [0:OUT1_H-1][0:OUT1_W-1],
   input  logic               fmap_valid,
   input  logic [3:0]         fmap_chan,
   output logic               busy,
   output logic               overrun,
   output logic [7:0]         out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2:0]         out_row,
   output logic [2:0]         out_col,
   output logic [3:0]         out_chan,
   output logic               out_last
);
   localparam int P_H    = OUT1_H / 2;
   localparam int P_W    = OUT1_W / 2;
   localparam int NBEATS = P_H * P_W;

   typedef enum logic {IDLE, EMIT} state_t;

   state_t             state_q, state_d;
   logic signed [23:0] fmap_q [0:OUT1_H-1][0:OUT1_W-1];
   logic [3:0]         chan_q;
   logic [5:0]         idx_q;
   logic [2:0]         row_q, col_q;
   logic               last_hs, accept, advance;
   logic [3:0]         r0, r1, c0, c1;
   logic [22:0]        a, b, c, d, m, q;
   logic [7:0]         pix;

   assign busy    = (state_q == EMIT);
   assign last_hs = out_valid && out_ready && out_last;
   assign accept  = fmap_valid && ((state_q == IDLE) || last_hs);
   assign advance = (state_q == EMIT) && (!out_valid || out_ready) && (idx_q < 6'(NBEATS));

   // Window corners: even/odd rows and columns of the pooled position.
   assign r0 = {row_q, 1'b0};
   assign r1 = {row_q, 1'b1};
   assign c0 = {col_q, 1'b0};
   assign c1 = {col_q, 1'b1};

   function automatic logic [22:0] relu(input logic signed [23:0] v);
      return v[23] ? 23'd0 : v[22:0];
   endfunction

   always_comb begin
      a   = relu(fmap_q[r0][c0]);
      b   = relu(fmap_q[r0][c1]);
      c   = relu(fmap_q[r1][c0]);
      d   = relu(fmap_q[r1][c1]);
      m   = (a > b) ? a : b;
      m   = (c > m) ? c : m;
      m   = (d > m) ? d : m;
      q   = m >> SHIFT;
      pix = (q > 23'd255) ? 8'hFF : q[7:0];
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      // NOTE: next-state defaults to the current state first, so no path leaves it unassigned (no latch).
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = EMIT;
         EMIT: if (last_hs && !fmap_valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the snapshot buffer is plain storage with no reset; it is always rewritten before it is read.
   always_ff @(posedge clk) begin
      if (accept) fmap_q <= fmap;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overrun   <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         out_row   <= '0;
         out_col   <= '0;
         out_chan  <= '0;
         chan_q    <= '0;
         idx_q     <= '0;
         row_q     <= '0;
         col_q     <= '0;
      end else begin
         if (fmap_valid && !accept) overrun <= 1'b1;
         if (accept) begin
            chan_q    <= fmap_chan;
            idx_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end else if (advance) begin
            out_data  <= pix;
            out_row   <= row_q;
            out_col   <= col_q;
            out_chan  <= chan_q;
            out_last  <= (idx_q == 6'(NBEATS - 1));
            out_valid <= 1'b1;
            idx_q     <= idx_q + 6'd1;
            if (col_q == 3'(P_W - 1)) begin
               col_q <= '0;
               row_q <= row_q + 3'd1;
            end else begin
               col_q <= col_q + 3'd1;
            end
         end else if (last_hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

   chan_in_range: assert property (@(posedge clk) disable iff (!rst_n)
      fmap_valid |-> (int'(fmap_chan) < CHAN));

endmodule

// File: tb/tb_conv1_relu_pool.sv
// Directed bench for conv1_relu_pool: two instances (SHIFT=0 and SHIFT=8) share stimulus
// so pooling order, requantisation, backpressure, overrun and reset are observed together.
module tb_conv1_relu_pool;
   localparam int H = 14, W = 13, PW = 6, NB = 42;

   logic clk = 1'b0, rst_n = 1'b0;
   logic signed [23:0] fmap    [0:H-1][0:W-1];
   logic signed [23:0] ref_map [0:H-1][0:W-1];
   logic       fmap_valid = 1'b0, out_ready = 1'b1;
   logic [3:0] fmap_chan = '0;

   logic busy0, overrun0, out_valid0, out_last0, busy8, overrun8, out_valid8, out_last8;
   logic [7:0] out_data0, out_data8;
   logic [2:0] out_row0, out_col0, out_row8, out_col8;
   logic [3:0] out_chan0, out_chan8;

   int n_cmp = 0, n_bad = 0;
   int n_beats, first_cyc, stall_err;
   logic [7:0] b_data0 [0:63];
   logic [7:0] b_data8 [0:63];
   logic [2:0] b_row [0:63];
   logic [2:0] b_col [0:63];
   logic [3:0] b_chan [0:63];
   logic       b_last [0:63];

   always #5 clk = ~clk;

   conv1_relu_pool #(.SHIFT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .fmap(fmap), .fmap_valid(fmap_valid), .fmap_chan(fmap_chan),
      .busy(busy0), .overrun(overrun0), .out_data(out_data0), .out_valid(out_valid0),
      .out_ready(out_ready), .out_row(out_row0), .out_col(out_col0), .out_chan(out_chan0),
      .out_last(out_last0));

   conv1_relu_pool #(.SHIFT(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .fmap(fmap), .fmap_valid(fmap_valid), .fmap_chan(fmap_chan),
      .busy(busy8), .overrun(overrun8), .out_data(out_data8), .out_valid(out_valid8),
      .out_ready(out_ready), .out_row(out_row8), .out_col(out_col8), .out_chan(out_chan8),
      .out_last(out_last8));

   function automatic int exp_pix(input int i, input int j, input int sh);
      longint m, v;
      m = 0;
      for (int dr = 0; dr < 2; dr++)
         for (int dc = 0; dc < 2; dc++) begin
            v = longint'(ref_map[2*i+dr][2*j+dc]);
            if (v < 0) v = 0;
            if (v > m) m = v;
         end
      m = m >> sh;
      return (m > 255) ? 255 : int'(m);
   endfunction

   task automatic fill_ramp();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) fmap[r][c] = 24'(r*13 + c);
   endtask

   task automatic fill_const(input logic signed [23:0] v);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) fmap[r][c] = v;
   endtask

   task automatic snap_ref();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) ref_map[r][c] = fmap[r][c];
   endtask

   // Pulse fmap_valid for one cycle; returns one cycle after the accepting edge.
   task automatic start_channel(input logic [3:0] ch);
      fmap_chan  = ch;
      fmap_valid = 1'b1;
      snap_ref();
      @(posedge clk); #1;
      fmap_valid = 1'b0;
   endtask

   // Collects handshaken beats; cycle 0 is the cycle after the accept edge.
   task automatic capture(input int ready_mode, input int max_beats, input int inject_cyc,
                          input bit accept_on_last);
      logic pv, pr, pl;
      logic [7:0] pd;
      logic [2:0] prw, pc;
      logic [3:0] pch;
      n_beats = 0; first_cyc = -1; stall_err = 0;
      pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0; prw = '0; pc = '0; pch = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (cyc > 0) begin @(posedge clk); #1; end
         fmap_valid = (cyc == inject_cyc);
         out_ready  = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         if (pv && !pr && ({out_valid0, out_data0, out_row0, out_col0, out_chan0, out_last0}
                           !== {1'b1, pd, prw, pc, pch, pl})) stall_err++;
         if (out_valid0 && first_cyc < 0) first_cyc = cyc;
         if (out_valid0 && out_ready && n_beats < 64) begin
            b_data0[n_beats] = out_data0; b_data8[n_beats] = out_data8;
            b_row[n_beats] = out_row0; b_col[n_beats] = out_col0;
            b_chan[n_beats] = out_chan0; b_last[n_beats] = out_last0;
            n_beats++;
            if (out_last0 && accept_on_last) fmap_valid = 1'b1;
         end
         pv = out_valid0; pr = out_ready; pd = out_data0; prw = out_row0;
         pc = out_col0; pch = out_chan0; pl = out_last0;
         if (out_valid0 && out_ready && (out_last0 || n_beats >= max_beats)) break;
      end
      @(posedge clk); #1;
      fmap_valid = 1'b0;
      out_ready  = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({out_valid0, out_last0, busy0, overrun0, out_data0, out_row0, out_col0, out_chan0,
           out_valid8, busy8} !== 24'd0) begin
         n_bad++;
         $display("FAIL reset_state: got v=%b l=%b b=%b o=%b d=%0d r=%0d c=%0d ch=%0d, need all 0",
                  out_valid0, out_last0, busy0, overrun0, out_data0, out_row0, out_col0, out_chan0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_ramp();
      fill_ramp();
      start_channel(4'd3);
      capture(0, NB, -1, 1'b0);
      n_cmp++;
      if (n_beats !== NB || first_cyc !== 1) begin
         n_bad++; $display("FAIL ramp_count: beats=%0d first_cyc=%0d, need %0d and 1", n_beats, first_cyc, NB);
      end
      n_cmp++;
      if ({b_data0[0], b_data0[5], b_data0[41]} !== {8'd14, 8'd24, 8'd180}) begin
         n_bad++; $display("FAIL ramp_spot: got %0d %0d %0d, need 14 24 180", b_data0[0], b_data0[5], b_data0[41]);
      end
      for (int k = 0; k < NB; k++) begin
         n_cmp++;
         if ({b_row[k], b_col[k], b_chan[k], b_last[k]} !== {3'(k/PW), 3'(k%PW), 4'd3, (k == NB-1)} ||
             b_data0[k] !== 8'(exp_pix(k/PW, k%PW, 0))) begin
            n_bad++;
            $display("FAIL ramp_beat%0d: got r=%0d c=%0d ch=%0d l=%b d=%0d, need r=%0d c=%0d ch=3 l=%b d=%0d",
                     k, b_row[k], b_col[k], b_chan[k], b_last[k], b_data0[k], k/PW, k%PW, k == NB-1,
                     exp_pix(k/PW, k%PW, 0));
         end
      end
      n_cmp++;
      if ({busy0, out_valid0} !== 2'b00) begin
         n_bad++; $display("FAIL ramp_idle: busy=%b valid=%b, need 0 0", busy0, out_valid0);
      end
   endtask

   task automatic test_const_relu();
      fill_const(24'sd1000);
      for (int r = 0; r < H; r++) fmap[r][12] = 24'sh7FFFFF;
      start_channel(4'd5);
      capture(0, NB, -1, 1'b0);
      n_cmp++;
      if (n_beats !== NB) begin n_bad++; $display("FAIL const_count: got %0d, need %0d", n_beats, NB); end
      for (int k = 0; k < NB; k++) begin
         n_cmp++;
         if ({b_data8[k], b_data0[k], b_chan[k]} !== {8'd3, 8'd255, 4'd5}) begin
            n_bad++;
            $display("FAIL const_beat%0d: got d8=%0d d0=%0d ch=%0d, need 3 255 5", k, b_data8[k], b_data0[k], b_chan[k]);
         end
      end
      fill_const(-24'sd500);
      start_channel(4'd6);
      capture(0, NB, -1, 1'b0);
      n_cmp++;
      if (n_beats !== NB) begin n_bad++; $display("FAIL relu_count: got %0d, need %0d", n_beats, NB); end
      for (int k = 0; k < NB; k++) begin
         n_cmp++;
         if ({b_data8[k], b_data0[k]} !== 16'd0) begin
            n_bad++; $display("FAIL relu_beat%0d: got d8=%0d d0=%0d, need 0 0", k, b_data8[k], b_data0[k]);
         end
      end
   endtask

   task automatic test_saturation();
      fill_const(24'sh7FFFFF);
      start_channel(4'd9);
      capture(0, NB, -1, 1'b0);
      n_cmp++;
      if (n_beats !== NB) begin n_bad++; $display("FAIL sat_count: got %0d, need %0d", n_beats, NB); end
      for (int k = 0; k < NB; k++) begin
         n_cmp++;
         if (b_data8[k] !== 8'd255) begin
            n_bad++; $display("FAIL sat_beat%0d: got %0d, need 255", k, b_data8[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      fill_ramp();
      start_channel(4'd3);
      capture(1, NB, -1, 1'b0);
      n_cmp++;
      if (n_beats !== NB || stall_err !== 0) begin
         n_bad++; $display("FAIL bp_count: beats=%0d unstable=%0d, need %0d and 0", n_beats, stall_err, NB);
      end
      for (int k = 0; k < NB; k++) begin
         n_cmp++;
         if ({b_row[k], b_col[k], b_last[k]} !== {3'(k/PW), 3'(k%PW), (k == NB-1)} ||
             b_data0[k] !== 8'(exp_pix(k/PW, k%PW, 0))) begin
            n_bad++;
            $display("FAIL bp_beat%0d: got r=%0d c=%0d l=%b d=%0d, need r=%0d c=%0d d=%0d",
                     k, b_row[k], b_col[k], b_last[k], b_data0[k], k/PW, k%PW, exp_pix(k/PW, k%PW, 0));
         end
      end
   endtask

   task automatic test_back_to_back();
      fill_ramp();
      start_channel(4'd3);
      fill_const(24'sd2000);
      fmap_chan = 4'd5;
      capture(0, NB, -1, 1'b1);
      n_cmp++;
      if (n_beats !== NB || b_data0[41] !== 8'd180) begin
         n_bad++; $display("FAIL b2b_first: beats=%0d last=%0d, need %0d and 180", n_beats, b_data0[41], NB);
      end
      n_cmp++;
      if ({busy0, out_valid0, overrun0} !== 3'b100) begin
         n_bad++; $display("FAIL b2b_accept: busy=%b valid=%b overrun=%b, need 1 0 0", busy0, out_valid0, overrun0);
      end
      snap_ref();
      capture(0, NB, -1, 1'b0);
      n_cmp++;
      if (n_beats !== NB || first_cyc !== 1) begin
         n_bad++; $display("FAIL b2b_second: beats=%0d first_cyc=%0d, need %0d and 1", n_beats, first_cyc, NB);
      end
      for (int k = 0; k < NB; k++) begin
         n_cmp++;
         if ({b_data8[k], b_chan[k]} !== {8'd7, 4'd5}) begin
            n_bad++; $display("FAIL b2b_beat%0d: got d8=%0d ch=%0d, need 7 5", k, b_data8[k], b_chan[k]);
         end
      end
   endtask

   task automatic test_overrun_snapshot();
      fill_ramp();
      start_channel(4'd3);
      fill_const(24'sd0);
      fmap_chan = 4'd7;
      capture(0, NB, 5, 1'b0);
      n_cmp++;
      if (n_beats !== NB || overrun0 !== 1'b1 || busy0 !== 1'b0) begin
         n_bad++; $display("FAIL ovr_state: beats=%0d overrun=%b busy=%b, need %0d 1 0", n_beats, overrun0, busy0, NB);
      end
      for (int k = 0; k < NB; k++) begin
         n_cmp++;
         if ({b_data0[k], b_chan[k]} !== {8'(exp_pix(k/PW, k%PW, 0)), 4'd3}) begin
            n_bad++;
            $display("FAIL snap_beat%0d: got d=%0d ch=%0d, need d=%0d ch=3", k, b_data0[k], b_chan[k], exp_pix(k/PW, k%PW, 0));
         end
      end
   endtask

   task automatic test_reset_midstream();
      fill_ramp();
      start_channel(4'd3);
      capture(0, 10, -1, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid0, busy0, overrun0} !== 3'b000 || n_beats !== 10) begin
         n_bad++;
         $display("FAIL mid_reset: valid=%b busy=%b overrun=%b beats=%0d, need 0 0 0 10", out_valid0, busy0, overrun0, n_beats);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      start_channel(4'd4);
      capture(0, NB, -1, 1'b0);
      n_cmp++;
      if (n_beats !== NB || first_cyc !== 1 || b_chan[0] !== 4'd4 || b_data0[41] !== 8'd180) begin
         n_bad++;
         $display("FAIL post_reset: beats=%0d first_cyc=%0d ch=%0d last=%0d, need %0d 1 4 180",
                  n_beats, first_cyc, b_chan[0], b_data0[41], NB);
      end
   endtask

   initial begin
      fill_const(24'sd0);
      test_reset();
      test_ramp();
      test_const_relu();
      test_saturation();
      test_backpressure();
      test_back_to_back();
      test_overrun_snapshot();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
